// File: rtl/branch_predictor_2bc_pkg.sv
// Shared encodings and helpers for the 2-bit-counter branch target buffer.
package branch_predictor_2bc_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  function automatic logic [1:0] sat_inc2(input logic [1:0] c);
    return (c == CTR_ST) ? CTR_ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec2(input logic [1:0] c);
    return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  // PC bits [1:0] are word-offset and take no part in index or tag.
  function automatic int tag_w(input int addr_w, input int entries);
    return addr_w - $clog2(entries) - 2;
  endfunction

endpackage

// File: rtl/branch_predictor_2bc_if.sv
// Fetch/decode-facing signal bundle of the branch predictor.
interface branch_predictor_2bc_if #(
  parameter int ADDR_W = 32,
  parameter int STAT_W = 16
);
  logic              lookup_en;
  logic [ADDR_W-1:0] lookup_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              update_en;
  logic [ADDR_W-1:0] update_pc;
  logic              update_taken;
  logic [ADDR_W-1:0] update_target;
  logic              update_mispredict;
  logic              flush;
  logic [STAT_W-1:0] stat_lookups;
  logic [STAT_W-1:0] stat_mispredicts;

  modport master (
    output lookup_en, lookup_pc, update_en, update_pc, update_taken,
           update_target, update_mispredict, flush,
    input  pred_hit, pred_taken, pred_target, stat_lookups, stat_mispredicts
  );

  modport slave (
    input  lookup_en, lookup_pc, update_en, update_pc, update_taken,
           update_target, update_mispredict, flush,
    output pred_hit, pred_taken, pred_target, stat_lookups, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor_2bc_stat.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module bp_stat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !(&cnt_q)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count = cnt_q;
endmodule

// File: rtl/branch_predictor_2bc.sv
// Direct-mapped BTB with 2-bit saturating direction counters, global flush
// and saturating lookup/mispredict statistics.
module branch_predictor_2bc
  import branch_predictor_2bc_pkg::*;
#(
  parameter int         ENTRIES  = 64,
  parameter int         ADDR_W   = 32,
  parameter logic [1:0] CTR_INIT = 2'b01,
  parameter int         STAT_W   = 16
) (
  input logic                   clk,
  input logic                   reset,
  branch_predictor_2bc_if.slave bp
);
  localparam int IDX_W = idx_w(ENTRIES);
  localparam int TAG_W = tag_w(ADDR_W, ENTRIES);

  logic [ENTRIES-1:0]             valid_q,  valid_d;
  logic [ENTRIES-1:0][TAG_W-1:0]  tag_q,    tag_d;
  logic [ENTRIES-1:0][ADDR_W-1:0] target_q, target_d;
  logic [ENTRIES-1:0][1:0]        ctr_q,    ctr_d;

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit;
  logic             unused_pc_lsbs;

  assign l_idx = bp.lookup_pc[IDX_W+1:2];
  assign l_tag = bp.lookup_pc[ADDR_W-1:IDX_W+2];
  assign u_idx = bp.update_pc[IDX_W+1:2];
  assign u_tag = bp.update_pc[ADDR_W-1:IDX_W+2];
  assign unused_pc_lsbs = ^{bp.lookup_pc[1:0], bp.update_pc[1:0]};

  // Lookup reads registered state only, so a same-cycle update is not visible.
  assign l_hit          = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign u_hit          = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign bp.pred_hit    = l_hit;
  assign bp.pred_taken  = l_hit && ctr_q[l_idx][1];
  assign bp.pred_target = l_hit ? target_q[l_idx] : '0;

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (bp.flush) begin
      valid_d = '0;
    end else if (bp.update_en) begin
      if (u_hit) begin
        if (bp.update_taken) begin
          ctr_d[u_idx]    = sat_inc2(ctr_q[u_idx]);
          target_d[u_idx] = bp.update_target;
        end else begin
          ctr_d[u_idx]    = sat_dec2(ctr_q[u_idx]);
        end
      end else if (bp.update_taken) begin
        // Taken miss allocates; not-taken misses leave the table alone.
        valid_d[u_idx]  = 1'b1;
        tag_d[u_idx]    = u_tag;
        target_d[u_idx] = bp.update_target;
        ctr_d[u_idx]    = CTR_WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      tag_q    <= '0;
      target_q <= '0;
      ctr_q    <= {ENTRIES{CTR_INIT}};
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

  bp_stat_counter #(.W(STAT_W)) u_stat_lookups (
    .clk   (clk),
    .reset (reset),
    .inc   (bp.lookup_en),
    .count (bp.stat_lookups)
  );

  bp_stat_counter #(.W(STAT_W)) u_stat_mispredicts (
    .clk   (clk),
    .reset (reset),
    .inc   (bp.update_en & bp.update_mispredict),
    .count (bp.stat_mispredicts)
  );
endmodule

// File: tb/tb_branch_predictor_2bc.sv
// Directed bench for branch_predictor_2bc (64 entries, 32-bit PC, 4-bit stats).
module tb_branch_predictor_2bc;
  localparam int ADDR_W = 32;
  localparam int STAT_W = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  branch_predictor_2bc_if #(.ADDR_W(ADDR_W), .STAT_W(STAT_W)) bp ();

  branch_predictor_2bc #(
    .ENTRIES (64),
    .ADDR_W  (ADDR_W),
    .CTR_INIT(2'b01),
    .STAT_W  (STAT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bp   (bp)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    bp.lookup_pc = pc;
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic mis);
    bp.update_en         = 1'b1;
    bp.update_pc         = pc;
    bp.update_taken      = tk;
    bp.update_target     = tgt;
    bp.update_mispredict = mis;
    tick();
    bp.update_en         = 1'b0;
    bp.update_mispredict = 1'b0;
  endtask

  task automatic expect_pred(input string tag, input logic [31:0] pc, input logic hit,
                             input logic tk, input logic [31:0] tgt);
    look(pc);
    chk({tag, ".hit"},    32'(bp.pred_hit),   32'(hit));
    chk({tag, ".taken"},  32'(bp.pred_taken), 32'(tk));
    chk({tag, ".target"}, bp.pred_target,     tgt);
  endtask

  initial begin
    reset = 1'b1;
    bp.lookup_en = 1'b0;         bp.lookup_pc = '0;
    bp.update_en = 1'b0;         bp.update_pc = '0;
    bp.update_taken = 1'b0;      bp.update_target = '0;
    bp.update_mispredict = 1'b0; bp.flush = 1'b0;
    tick(); tick();
    reset = 1'b0;

    expect_pred("rst", 32'h40, 1'b0, 1'b0, 32'h0);
    chk("rst.stat_lookups", 32'(bp.stat_lookups),     32'h0);
    chk("rst.stat_mispred", 32'(bp.stat_mispredicts), 32'h0);

    // Allocation on taken miss: ctr=10
    upd(32'h100, 1'b1, 32'h200, 1'b0);
    expect_pred("alloc", 32'h100, 1'b1, 1'b1, 32'h200);

    // Down to 00 and hold there
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    expect_pred("nt1", 32'h100, 1'b1, 1'b0, 32'h200);
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    expect_pred("nt2", 32'h100, 1'b1, 1'b0, 32'h200);
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    // Up: 01, 10, 11, 11 with target overwritten
    upd(32'h100, 1'b1, 32'h204, 1'b0);
    expect_pred("t1_01", 32'h100, 1'b1, 1'b0, 32'h204);
    upd(32'h100, 1'b1, 32'h204, 1'b0);
    expect_pred("t2_10", 32'h100, 1'b1, 1'b1, 32'h204);
    upd(32'h100, 1'b1, 32'h204, 1'b0);
    upd(32'h100, 1'b1, 32'h208, 1'b0);
    expect_pred("t4_11", 32'h100, 1'b1, 1'b1, 32'h208);
    // Saturated at 11: one NT gives 10 (taken), second gives 01
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    expect_pred("sat_nt1", 32'h100, 1'b1, 1'b1, 32'h208);
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    expect_pred("sat_nt2", 32'h100, 1'b1, 1'b0, 32'h208);

    // Alias at index 0, different tag
    upd(32'h200, 1'b1, 32'h300, 1'b0);
    expect_pred("alias_old", 32'h100, 1'b0, 1'b0, 32'h0);
    expect_pred("alias_new", 32'h200, 1'b1, 1'b1, 32'h300);
    expect_pred("pc_lsbs",   32'h203, 1'b1, 1'b1, 32'h300);

    // Not-taken miss does not allocate
    upd(32'h500, 1'b0, 32'h600, 1'b0);
    expect_pred("ntmiss_new", 32'h500, 1'b0, 1'b0, 32'h0);
    expect_pred("ntmiss_old", 32'h200, 1'b1, 1'b1, 32'h300);

    // Flush with same-cycle update: lookup sees old entry, update dropped
    bp.flush = 1'b1;
    bp.update_en = 1'b1; bp.update_pc = 32'h100;
    bp.update_taken = 1'b1; bp.update_target = 32'h400;
    expect_pred("flush_same", 32'h200, 1'b1, 1'b1, 32'h300);
    tick();
    bp.flush = 1'b0; bp.update_en = 1'b0;
    expect_pred("flush_200", 32'h200, 1'b0, 1'b0, 32'h0);
    expect_pred("flush_100", 32'h100, 1'b0, 1'b0, 32'h0);

    // No bypass: update visible only after the edge
    bp.update_en = 1'b1; bp.update_pc = 32'h84;
    bp.update_taken = 1'b1; bp.update_target = 32'h88;
    expect_pred("nobyp_same", 32'h84, 1'b0, 1'b0, 32'h0);
    tick();
    bp.update_en = 1'b0;
    expect_pred("nobyp_next", 32'h84, 1'b1, 1'b1, 32'h88);

    // Stats
    chk("stat_pre", 32'(bp.stat_lookups), 32'h0);
    bp.lookup_en = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("stat_lk14", 32'(bp.stat_lookups), 32'd14);
    for (int i = 0; i < 6; i++) tick();
    bp.lookup_en = 1'b0;
    chk("stat_lk_sat", 32'(bp.stat_lookups), 32'd15);
    for (int i = 0; i < 3; i++) upd(32'h1000, 1'b0, 32'h0, 1'b1);
    bp.update_mispredict = 1'b1;   // without update_en: must not count
    tick();
    bp.update_mispredict = 1'b0;
    chk("stat_mis", 32'(bp.stat_mispredicts), 32'd3);

    // Mid-run reset; update and lookup in the reset cycle are ignored
    reset = 1'b1;
    bp.lookup_en = 1'b1;
    bp.update_en = 1'b1; bp.update_pc = 32'h100; bp.update_taken = 1'b1;
    bp.update_target = 32'h500; bp.update_mispredict = 1'b1;
    tick();
    reset = 1'b0;
    bp.lookup_en = 1'b0; bp.update_en = 1'b0; bp.update_mispredict = 1'b0;
    chk("mrst.stat_lookups", 32'(bp.stat_lookups),     32'h0);
    chk("mrst.stat_mispred", 32'(bp.stat_mispredicts), 32'h0);
    expect_pred("mrst_100", 32'h100, 1'b0, 1'b0, 32'h0);
    expect_pred("mrst_84",  32'h84,  1'b0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
